alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  EX-stage ALU. Consumes 3-bit aluOp from the ALU control decoder plus two register operands.
//  Single-cycle: add/sub/and/or/unsigned-add. Iterative (multi-cycle): signed mul/div.
//  Stalls the upstream pipeline while an iteration runs; registered result feeds EX/MEM.
// PARAMETERS
//  WIDTH  16  datapath width; mul product and div quotient/remainder are split across result/result_hi
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      EX holds a valid instruction
//  alu_op     in   3      000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 uadd, 111 halt
//  op_a       in   WIDTH  operand A (dividend / multiplicand)
//  op_b       in   WIDTH  operand B (divisor / multiplier)
//  flush      in   1      squash current/in-flight op (branch/hazard)
//  stall      out  1      hold IF/ID/EX pipeline registers
//  out_valid  out  1      result registers hold a new result (1-cycle pulse)
//  result     out  WIDTH  sum/diff/logic/product low/quotient
//  result_hi  out  WIDTH  product high / remainder; 0 for single-cycle ops
//  zero       out  1      result == 0
//  ovf        out  1      signed add/sub overflow, or MIN/-1 divide
//  div_zero   out  1      divide by zero
//  halt       out  1      sticky halt seen
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, FSM=IDLE, counter=0; takes effect mid-operation too.
//  FSM: IDLE -> BUSY (accept mul/div) -> FIX (sign fixup, write) -> IDLE.
//  Accept: state==IDLE & in_valid & !flush & !halt.
//  Single-cycle op accepted in cycle N: result/flags registered, out_valid=1 in cycle N+1; no stall.
//  Mul/div accepted in cycle N: BUSY cycles N+1..N+WIDTH (counter WIDTH-1 down to 0), FIX cycle N+WIDTH+1,
//   out_valid=1 in cycle N+WIDTH+2. Operands latched at accept; op_a/op_b ignored afterwards.
//  stall = (IDLE & in_valid & op in {010,011} & !flush & !halt) | BUSY. stall=0 in FIX so upstream
//   advances on the same edge that writes the result; no re-accept of the same instruction.
//  Add/sub: two's complement mod 2^WIDTH; ovf = operand signs agree (sub: A vs ~B) and result sign differs.
//  uadd: mod 2^WIDTH, ovf=0. and/or: bitwise, ovf=0. zero tracks result for every op.
//  Mul: shift-add on magnitudes, negate 2*WIDTH product in FIX if signs differ; {result_hi,result}=product.
//  Div: restoring on magnitudes; quotient sign = sign(A)^sign(B), remainder sign = sign(A) (truncating).
//  Div by zero: full latency kept; result=0, result_hi=op_a, div_zero=1.
//  MIN / -1: result=MIN (0x8000), result_hi=0, ovf=1.
//  Halt (111): out_valid=1 next cycle, result=0, halt=1 sticky until reset; later in_valid ignored.
//  flush: synchronous, priority over accept; BUSY/FIX -> IDLE, no out_valid, stall deasserts next cycle.
//   flush in same cycle as an accept-eligible op: op dropped.
//  out_valid is a single-cycle pulse; result/flags hold until the next out_valid.
// STRUCTURE
//  Shared header alu_defs: ALU_ADD..ALU_HALT 3-bit localparams (same encoding the control decoder emits),
//   FSM state encodings.
//  Sub-module alu_iter_muldiv: operand latch, magnitude conversion, WIDTH-step shift-add/restoring
//   core, fixup; start/busy/done handshake. Top holds single-cycle ALU, stall logic, output regs.
// TESTING (WIDTH=16)
//  ADD 0x7FFF+0x0001 -> out_valid next cycle, result 0x8000, ovf=1, stall never high; OR 0x00F0|0x0F00 -> 0x0FF0.
//  MUL -3*7 -> stall 17 cycles, out_valid cycle N+18, {result_hi,result}=0xFFFF_FFEB, zero=0.
//  DIV -7/2 -> result 0xFFFD, result_hi 0xFFFF; DIV 0x8000/0xFFFF -> result 0x8000, ovf=1.
//  DIV 5/0 -> after 18 cycles div_zero=1, result 0, result_hi 0x0005; then ADD 1+1 -> 0x0002, div_zero=0.
//  flush at 5th BUSY cycle of MUL -> no out_valid, stall 0 next cycle; following ADD completes normally;
//   rst_n low mid-DIV -> all outputs 0 immediately, FSM IDLE.
//  HALT -> halt=1, out_valid pulse, result 0; subsequent ADD with in_valid=1 -> no out_valid, stall=0.

Source files
------------

// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU opcode encodings (as emitted by the ALU control decoder) and iterative-unit FSM states.
package alu_exec_unit_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 3'b000;
  localparam alu_op_t ALU_SUB  = 3'b001;
  localparam alu_op_t ALU_MUL  = 3'b010;
  localparam alu_op_t ALU_DIV  = 3'b011;
  localparam alu_op_t ALU_AND  = 3'b100;
  localparam alu_op_t ALU_OR   = 3'b101;
  localparam alu_op_t ALU_UADD = 3'b110;
  localparam alu_op_t ALU_HALT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

  // Ops that run on the multi-cycle mul/div unit
  function automatic logic is_iter_op(input alu_op_t op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/alu_exec_unit_muldiv.sv
// Iterative signed mul/div: latches operands on start, runs WIDTH shift-add / restoring steps
// on magnitudes, then applies sign fixup during the FIX cycle (done_c high).
module alu_exec_unit_muldiv
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             idle,
  output logic             busy,
  output logic             done_c,
  output logic [WIDTH-1:0] res_lo_c,
  output logic [WIDTH-1:0] res_hi_c,
  output logic             ovf_c,
  output logic             div_zero_c
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_t        state;
  logic [CW-1:0]    cnt;
  logic             div_q;
  logic             neg_lo;     // product sign (mul) / quotient sign (div)
  logic             neg_hi;     // remainder sign (div)
  logic             bzero;
  logic             min_neg1;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] mop;        // multiplicand or divisor magnitude
  logic [WIDTH-1:0] hi;         // product high / partial remainder
  logic [WIDTH-1:0] lo;         // multiplier / dividend shifting into quotient

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     rsh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_f;
  logic [WIDTH-1:0]   quo_f;
  logic [WIDTH-1:0]   rem_f;

  assign mag_a = op_a[WIDTH-1] ? -op_a : op_a;
  assign mag_b = op_b[WIDTH-1] ? -op_b : op_b;

  assign add_s = {1'b0, hi} + {1'b0, (lo[0] ? mop : {WIDTH{1'b0}})};
  assign rsh   = {hi, lo[WIDTH-1]};
  assign diff  = rsh - {1'b0, mop};

  assign prod   = {hi, lo};
  assign prod_f = neg_lo ? -prod : prod;
  assign quo_f  = neg_lo ? -lo : lo;
  assign rem_f  = neg_hi ? -hi : hi;

  assign idle   = (state == ST_IDLE);
  assign busy   = (state == ST_BUSY);
  assign done_c = (state == ST_FIX);

  // FSM, operand latch and one shift-add / restoring step per BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      div_q    <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      bzero    <= 1'b0;
      min_neg1 <= 1'b0;
      a_q      <= '0;
      mop      <= '0;
      hi       <= '0;
      lo       <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_BUSY;
            cnt      <= CW'(WIDTH - 1);
            div_q    <= is_div;
            neg_lo   <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            neg_hi   <= op_a[WIDTH-1];
            bzero    <= (op_b == '0);
            min_neg1 <= (op_a == MIN_VAL) && (op_b == '1);
            a_q      <= op_a;
            mop      <= is_div ? mag_b : mag_a;
            lo       <= is_div ? mag_a : mag_b;
            hi       <= '0;
          end
        end
        ST_BUSY: begin
          if (div_q) begin
            if (!diff[WIDTH]) begin
              hi <= diff[WIDTH-1:0];
              lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
              hi <= rsh[WIDTH-1:0];
              lo <= {lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            hi <= add_s[WIDTH:1];
            lo <= {add_s[0], lo[WIDTH-1:1]};
          end
          if (cnt == '0) begin
            state <= ST_FIX;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_FIX:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sign fixup and special-case divide results presented during FIX
  always_comb begin
    res_lo_c   = '0;
    res_hi_c   = '0;
    ovf_c      = 1'b0;
    div_zero_c = 1'b0;
    if (!div_q) begin
      res_lo_c = prod_f[WIDTH-1:0];
      res_hi_c = prod_f[2*WIDTH-1:WIDTH];
    end else if (bzero) begin
      res_hi_c   = a_q;
      div_zero_c = 1'b1;
    end else if (min_neg1) begin
      res_lo_c = MIN_VAL;
      ovf_c    = 1'b1;
    end else begin
      res_lo_c = quo_f;
      res_hi_c = rem_f;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle add/sub/and/or/uadd/halt, iterative signed mul/div with pipeline stall.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             ovf,
  output logic             div_zero,
  output logic             halt
);

  logic             md_idle;
  logic             md_busy;
  logic             md_done_c;
  logic [WIDTH-1:0] md_lo_c;
  logic [WIDTH-1:0] md_hi_c;
  logic             md_ovf_c;
  logic             md_dz_c;

  logic             is_iter;
  logic             accept;
  logic             md_start;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] dif_c;
  logic [WIDTH-1:0] sc_res_c;
  logic             sc_ovf_c;

  assign is_iter  = is_iter_op(alu_op);
  assign accept   = md_idle & in_valid & ~flush & ~halt;
  assign md_start = accept & is_iter;
  // Hold upstream from the accept cycle through the last BUSY cycle; FIX lets it advance
  assign stall    = md_start | md_busy;

  assign sum_c = op_a + op_b;
  assign dif_c = op_a - op_b;

  // Single-cycle result and signed overflow
  always_comb begin
    sc_res_c = '0;
    sc_ovf_c = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        sc_res_c = sum_c;
        sc_ovf_c = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_c[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_res_c = dif_c;
        sc_ovf_c = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (dif_c[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_AND:  sc_res_c = op_a & op_b;
      ALU_OR:   sc_res_c = op_a | op_b;
      ALU_UADD: sc_res_c = sum_c;
      default:  sc_res_c = '0;
    endcase
  end

  alu_exec_unit_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (md_start),
    .is_div     (alu_op == ALU_DIV),
    .flush      (flush),
    .op_a       (op_a),
    .op_b       (op_b),
    .idle       (md_idle),
    .busy       (md_busy),
    .done_c     (md_done_c),
    .res_lo_c   (md_lo_c),
    .res_hi_c   (md_hi_c),
    .ovf_c      (md_ovf_c),
    .div_zero_c (md_dz_c)
  );

  // Output registers: written by an unflushed mul/div FIX cycle or a single-cycle accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      div_zero  <= 1'b0;
      halt      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (md_done_c && !flush) begin
        out_valid <= 1'b1;
        result    <= md_lo_c;
        result_hi <= md_hi_c;
        zero      <= (md_lo_c == '0);
        ovf       <= md_ovf_c;
        div_zero  <= md_dz_c;
      end else if (accept && !is_iter) begin
        out_valid <= 1'b1;
        result    <= sc_res_c;
        result_hi <= '0;
        zero      <= (sc_res_c == '0);
        ovf       <= sc_ovf_c;
        div_zero  <= 1'b0;
        if (alu_op == ALU_HALT) begin
          halt <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit (WIDTH=16); expected values are hand-computed.
module tb_alu_exec_unit;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [2:0]   alu_op;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         flush;
  logic         stall;
  logic         out_valid;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         ovf;
  logic         div_zero;
  logic         halt;

  int errors = 0;
  int checks = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .alu_op    (alu_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .stall     (stall),
    .out_valid (out_valid),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .ovf       (ovf),
    .div_zero  (div_zero),
    .halt      (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Single-cycle op: no stall, result one cycle later, single-cycle out_valid pulse
  task automatic run_sc(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic eovf);
    @(negedge clk);
    in_valid = 1'b1; alu_op = op; op_a = a; op_b = b;
    #1;
    check({tag, " stall"}, 32'(stall), 32'd0);
    @(negedge clk);
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " result"}, 32'(result), 32'(er));
    check({tag, " result_hi"}, 32'(result_hi), 32'd0);
    check({tag, " ovf"}, 32'(ovf), 32'(eovf));
    check({tag, " zero"}, 32'(zero), 32'(er == '0));
    check({tag, " div_zero"}, 32'(div_zero), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, " pulse"}, 32'(out_valid), 32'd0);
    check({tag, " hold"}, 32'(result), 32'(er));
  endtask

  // Mul/div: 17 stall cycles, out_valid 18 cycles after the accept cycle
  task automatic run_md(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic [W-1:0] eh,
                        input logic eovf, input logic edz);
    int stalls;
    int lat;
    logic got;
    @(negedge clk);
    in_valid = 1'b1; alu_op = op; op_a = a; op_b = b;
    #1;
    stalls = stall ? 1 : 0;
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        lat = k;
        check({tag, " result"}, 32'(result), 32'(er));
        check({tag, " result_hi"}, 32'(result_hi), 32'(eh));
        check({tag, " ovf"}, 32'(ovf), 32'(eovf));
        check({tag, " div_zero"}, 32'(div_zero), 32'(edz));
        check({tag, " zero"}, 32'(zero), 32'(er == '0));
      end else if (stall) begin
        stalls++;
      end
      in_valid = 1'b0;
      op_a = 16'hDEAD; op_b = 16'hBEEF;
    end
    check({tag, " latency"}, 32'(lat), 32'd18);
    check({tag, " stall cycles"}, 32'(stalls), 32'd17);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; in_valid = 1'b0; alu_op = 3'b000; op_a = '0; op_b = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", 32'(result), 32'd0);
    check("rst result_hi", 32'(result_hi), 32'd0);
    check("rst flags", 32'({zero, ovf, div_zero, halt}), 32'd0);
    check("rst stall", 32'(stall), 32'd0);
    rst_n = 1'b1;

    // Single-cycle ops
    run_sc("add ovf", 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1'b1);
    run_sc("or", 3'b101, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0);
    run_sc("sub ovf", 3'b001, 16'h8000, 16'h0001, 16'h7FFF, 1'b1);
    run_sc("sub neg", 3'b001, 16'h0003, 16'h0005, 16'hFFFE, 1'b0);
    run_sc("and", 3'b100, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0);
    run_sc("uadd wrap", 3'b110, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);

    // Multi-cycle ops
    run_md("mul -3*7", 3'b010, 16'hFFFD, 16'h0007, 16'hFFEB, 16'hFFFF, 1'b0, 1'b0);
    run_md("mul 300*300", 3'b010, 16'd300, 16'd300, 16'h5F90, 16'h0001, 1'b0, 1'b0);
    run_md("div -7/2", 3'b011, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
    run_md("div 100/-7", 3'b011, 16'd100, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0);
    run_md("div min/-1", 3'b011, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b1, 1'b0);
    run_md("div 5/0", 3'b011, 16'h0005, 16'h0000, 16'h0000, 16'h0005, 1'b0, 1'b1);
    run_sc("add after dz", 3'b000, 16'h0001, 16'h0001, 16'h0002, 1'b0);

    // Flush on the fifth BUSY cycle of a MUL
    @(negedge clk);
    in_valid = 1'b1; alu_op = 3'b010; op_a = 16'd100; op_b = 16'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("flush busy stall", 32'(stall), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush stall drop", 32'(stall), 32'd0);
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("flush no out_valid", 32'(pulses), 32'd0);
    run_sc("add after flush", 3'b000, 16'h0003, 16'h0004, 16'h0007, 1'b0);

    // Flush alongside an accept-eligible MUL drops it
    @(negedge clk);
    in_valid = 1'b1; alu_op = 3'b010; op_a = 16'd2; op_b = 16'd2; flush = 1'b1;
    #1;
    check("flush accept stall", 32'(stall), 32'd0);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush accept busy", 32'(stall), 32'd0);
    check("flush accept out_valid", 32'(out_valid), 32'd0);

    // Async reset in the middle of a DIV
    run_sc("add pre-rst", 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; alu_op = 3'b011; op_a = 16'd100; op_b = 16'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid rst result", 32'(result), 32'd0);
    check("mid rst flags", 32'({out_valid, zero, ovf, div_zero, halt}), 32'd0);
    check("mid rst stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid || stall) pulses++;
    end
    check("mid rst idle", 32'(pulses), 32'd0);
    run_md("div 100/7", 3'b011, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0);

    // Halt is sticky and blocks later accepts
    @(negedge clk);
    in_valid = 1'b1; alu_op = 3'b111; op_a = 16'h1234; op_b = 16'h5678;
    @(negedge clk);
    check("halt out_valid", 32'(out_valid), 32'd1);
    check("halt flag", 32'(halt), 32'd1);
    check("halt result", 32'(result), 32'd0);
    alu_op = 3'b000; op_a = 16'd1; op_b = 16'd1;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid || stall) pulses++;
    end
    check("halt ignores add", 32'(pulses), 32'd0);
    alu_op = 3'b010;
    #1;
    check("halt mul stall", 32'(stall), 32'd0);
    @(negedge clk);
    check("halt sticky", 32'(halt), 32'd1);
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
